// File: rtl/kernel3_gmem_c_m_axi_burst_split.sv
// Splits a beat-count request into AXI bursts that stay inside 4 KB pages
// and never exceed MAX_BURST beats, issuing one burst per cycle.
module kernel3_gmem_c_m_axi_burst_split #(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int BUS_BYTES  = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_len,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int OFF = $clog2(BUS_BYTES);
  localparam int BW  = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                state;
  state_t                state_nx;
  logic                  rdy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [12:0]           pg13;
  logic [BW-1:0]         rem_w;
  logic [BW-1:0]         pg_w;
  logic [BW-1:0]         beats;
  logic                  accept;
  logic                  fire;

  assign accept = in_valid && rdy_q && (state == IDLE);
  assign fire   = out_valid && out_ready;

  // Beats left before the next 4 KB page starts bound the burst.
  always_comb begin
    pg13  = (13'h1000 - {1'b0, addr_q[11:0]}) >> OFF;
    rem_w = BW'(rem_q);
    pg_w  = BW'(pg13);
    beats = rem_w;
    if (pg_w < beats)
      beats = pg_w;
    if (BW'(MAX_BURST) < beats)
      beats = BW'(MAX_BURST);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx == IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept && (in_len != '0))
          state_nx = SPLIT;
      SPLIT:
        if (fire && out_last)
          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rem_q <= '0;
    else if (accept)
      rem_q <= in_len;
    else if (fire)
      rem_q <= out_last ? '0 : rem_q - LEN_WIDTH'(beats);
  end

  always_ff @(posedge clk) begin
    if (accept)
      addr_q <= in_addr & ~ADDR_WIDTH'(BUS_BYTES - 1);
    else if (fire && !out_last)
      addr_q <= addr_q + (ADDR_WIDTH'(beats) << OFF);
  end

  always_comb begin
    out_valid = (state == SPLIT);
    in_ready  = rdy_q;
    out_addr  = addr_q;
    out_len   = 8'(beats - BW'(1));
    out_last  = (state == SPLIT) && (beats == rem_w);
  end

endmodule

// File: doc/kernel3_gmem_c_m_axi_burst_split.md
KERNEL3_GMEM_C_M_AXI_BURST_SPLIT -- requirements
Module: kernel3_gmem_C_m_axi_burst_split

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 32, width of the request length in beats.
REQ-003 SHALL have parameter BUS_BYTES, default 64, data bus width in bytes, power of 2.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per burst, power of 2, 1..256.
REQ-005 SHALL have port clk  input  1  clock; sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port in_addr  input  ADDR_WIDTH  start byte address of request.
REQ-008 SHALL have port in_len  input  LEN_WIDTH  request length in beats, 0 permitted.
REQ-009 SHALL have port in_valid  input  1  request valid.
REQ-010 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port out_addr  output  ADDR_WIDTH  burst start byte address.
REQ-012 SHALL have port out_len  output  8  burst length, AXI encoding (beats-1).
REQ-013 SHALL have port out_last  output  1  high on the final burst of a request.
REQ-014 SHALL have port out_valid  output  1  burst valid; drives the downstream register slice s_valid.
REQ-015 SHALL have port out_ready  input  1  burst accepted when out_valid and out_ready are both high.

Function
REQ-016 SHALL implement two states: IDLE (in_ready=1, out_valid=0) and SPLIT (in_ready=0, out_valid=1).
REQ-017 SHALL force the low log2(BUS_BYTES) bits of an accepted in_addr to zero.
REQ-018 SHALL, on an IDLE accept with in_len!=0, register the aligned address and remaining=in_len, and enter SPLIT with out_valid=1 the next cycle (1-cycle latency).
REQ-019 SHALL, on an IDLE accept with in_len==0, stay in IDLE, produce no burst, and keep in_ready=1.
REQ-020 SHALL size each burst as beats = min(remaining, MAX_BURST, (4096 - (addr mod 4096)) / BUS_BYTES).
REQ-021 SHALL drive out_len = beats-1 and out_addr = current registered address.
REQ-022 SHALL drive out_last=1 iff beats == remaining.
REQ-023 SHALL, on an out handshake with out_last=0, add beats*BUS_BYTES to the address (modulo 2^ADDR_WIDTH) and subtract beats from remaining.
REQ-024 SHALL present the next burst in the following cycle with out_valid held high (one burst per cycle sustained).
REQ-025 SHALL, on an out handshake with out_last=1, return to IDLE: out_valid=0 and in_ready=1 the next cycle.
REQ-026 SHALL hold out_addr, out_len, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never emit a burst crossing a 4 KB boundary or exceeding MAX_BURST beats.
REQ-028 SHALL ignore in_valid while in SPLIT; no request is lost, since in_ready=0 there.
REQ-029 SHALL register in_ready; it is not combinationally dependent on in_valid or out_ready.

Reset
REQ-030 SHALL, while reset_n=0 at a clk edge, enter IDLE with out_valid=0, in_ready=0, out_last=0 and remaining=0.
REQ-031 SHALL assert in_ready=1 in the first cycle after reset_n returns high.
REQ-032 SHALL, on reset during SPLIT, discard the pending request; no further bursts are issued for it.
REQ-033 SHALL not require reset on the out_addr and out_len datapath registers.

Verification
REQ-034 SHALL cover: addr=0x0, len=40, out_ready=1 -> bursts (0x000,15,last0), (0x400,15,last0), (0x800,7,last1) on consecutive cycles.
REQ-035 SHALL cover: addr=0xFC0, len=4 -> (0xFC0,0,last0), then (0x1000,2,last1).
REQ-036 SHALL cover: len=0 accepted -> out_valid stays 0 and in_ready stays 1.
REQ-037 SHALL cover: addr=0x0, len=20 with out_ready=0 for 5 cycles -> (0x000,15,last0) held stable, then (0x400,3,last1) after out_ready rises.
REQ-038 SHALL cover: reset_n=0 during second burst of len=40 -> out_valid=0 next cycle, in_ready=0 during reset, 1 after release, no residual bursts.
REQ-039 SHALL cover: addr=0x10, len=1 -> single burst (0x0,0,last1).
